lfsr_seq_checker: RTL and testbench



---
 rtl/lfsr_seq_checker.sv | 165 ++++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: receive-side checker for the 10-bit XNOR LFSR pattern
// (taps 9 and 6, seed all-zeros). It fills a history register, self-syncs
// to the stream, declares lock and then flywheels, flagging and counting
// bit errors.
// Optional build macro: LFSR_SEQ_CHECKER_BITCNT_EN adds a 32-bit count of
// bits checked while locked (BER denominator alongside err_count).
module lfsr_seq_checker #(
  parameter int LOCK_CNT    = 20,  // consecutive good predictions to lock (1..255)
  parameter int UNLOCK_ERRS = 4,   // consecutive mispredictions to drop lock (1..15)
  parameter int CNT_W       = 16   // width of the saturating error counter
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count
`ifdef LFSR_SEQ_CHECKER_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_C   = 8'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_ERRS);

  state_t           state_q, state_d;
  logic [9:0]       hist_q, hist_d;
  logic [3:0]       fill_cnt_q, fill_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       err_run_q, err_run_d;
  logic             bit_err_q, bit_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             pred_bit;
  logic             err_inc;

  // Next bit predicted from the history: b[n] = b[n-10] XNOR b[n-7].
  assign pred_bit = ~(hist_q[9] ^ hist_q[6]);

  // Next-state logic for the fill / search / locked sequencer.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    err_run_d   = err_run_q;
    bit_err_d   = 1'b0;
    err_inc     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        ST_FILL: begin
          hist_d = {hist_q[8:0], in_bit};
          if (fill_cnt_q == 4'd9) begin
            state_d     = ST_SEARCH;
            fill_cnt_d  = 4'd0;
            match_cnt_d = 8'd0;
          end else begin
            fill_cnt_d = fill_cnt_q + 4'd1;
          end
        end
        ST_SEARCH: begin
          // Self-sync: always take the received bit into the history.
          hist_d = {hist_q[8:0], in_bit};
          if (hist_q == 10'h3FF) begin
            // All-ones is the XNOR lock-up state; it predicts itself forever.
            match_cnt_d = 8'd0;
          end else if (in_bit == pred_bit) begin
            match_cnt_d = match_cnt_q + 8'd1;
          end else begin
            match_cnt_d = 8'd0;
          end
          if (match_cnt_d == LOCK_C) begin
            state_d   = ST_LOCKED;
            err_run_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: history follows the prediction so one bad bit is one error.
          hist_d = {hist_q[8:0], pred_bit};
          if (in_bit != pred_bit) begin
            bit_err_d = 1'b1;
            err_inc   = 1'b1;
            err_run_d = err_run_q + 4'd1;
            if (err_run_d == UNLOCK_C) begin
              state_d     = ST_SEARCH;
              match_cnt_d = 8'd0;
            end
          end else begin
            err_run_d = 4'd0;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  // Saturating error counter; clear wins over a simultaneous increment.
  always_comb begin
    err_count_d = err_count_q;
    if (clear_cnt) begin
      err_count_d = '0;
    end else if (err_inc && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      hist_q      <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      err_run_q   <= '0;
      bit_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      err_run_q   <= err_run_d;
      bit_err_q   <= bit_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign bit_err   = bit_err_q;
  assign err_count = err_count_q;

`ifdef LFSR_SEQ_CHECKER_BITCNT_EN
  logic [31:0] bit_count_q, bit_count_d;

  // Count of valid bits checked while locked; saturates, clears with clear_cnt.
  always_comb begin
    bit_count_d = bit_count_q;
    if (clear_cnt) begin
      bit_count_d = '0;
    end else if (in_valid && (state_q == ST_LOCKED) && (bit_count_q != 32'hFFFF_FFFF)) begin
      bit_count_d = bit_count_q + 32'd1;
    end
  end

  // Bit counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Testbench for lfsr_seq_checker: randomized generator stream with injected
// errors and valid gaps, checked cycle by cycle against a behavioural model
// through a scoreboard queue. A second instance with a 4-bit counter covers
// saturation.
module tb_lfsr_seq_checker;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_bit;
  logic        clear_cnt;
  logic        locked, bit_err;
  logic [15:0] err_count;
  logic        locked_s, bit_err_s;
  logic [3:0]  err_count_s;
`ifdef LFSR_SEQ_CHECKER_BITCNT_EN
  logic [31:0] bit_count, bit_count_s;
`endif

  lfsr_seq_checker #(.LOCK_CNT(20), .UNLOCK_ERRS(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear_cnt(clear_cnt), .locked(locked), .bit_err(bit_err),
    .err_count(err_count)
`ifdef LFSR_SEQ_CHECKER_BITCNT_EN
    , .bit_count(bit_count)
`endif
  );

  lfsr_seq_checker #(.LOCK_CNT(20), .UNLOCK_ERRS(4), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear_cnt(clear_cnt), .locked(locked_s), .bit_err(bit_err_s),
    .err_count(err_count_s)
`ifdef LFSR_SEQ_CHECKER_BITCNT_EN
    , .bit_count(bit_count_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lk;
    logic        be;
    logic [15:0] ec;
    logic [3:0]  ecs;
    logic [31:0] bc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // ---------------- behavioural reference model ----------------
  localparam int M_FILL = 0, M_SEARCH = 1, M_LOCKED = 2;
  int m_state = M_FILL;
  bit m_h[$];          // received/flywheel history, oldest first, up to 10 bits
  int m_match = 0;
  int m_run = 0;
  int m_errs = 0;      // errors since last clear (unbounded)
  int m_bits = 0;      // bits checked while locked since last clear

  task automatic model_update(input bit v, input bit b, input bit c, input bit r,
                              output exp_t e);
    bit err = 0;
    bit counted = 0;
    bit p, allones;
    if (r) begin
      m_state = M_FILL; m_h.delete(); m_match = 0; m_run = 0; m_errs = 0; m_bits = 0;
    end else begin
      if (v) begin
        case (m_state)
          M_FILL: begin
            m_h.push_back(b);
            if (m_h.size() == 10) begin m_state = M_SEARCH; m_match = 0; end
          end
          M_SEARCH: begin
            p = !(m_h[0] ^ m_h[3]);
            allones = 1;
            foreach (m_h[k]) if (!m_h[k]) allones = 0;
            m_h.push_back(b); void'(m_h.pop_front());
            if (allones) m_match = 0;
            else if (b == p) m_match++;
            else m_match = 0;
            if (m_match == 20) begin m_state = M_LOCKED; m_run = 0; end
          end
          default: begin
            p = !(m_h[0] ^ m_h[3]);
            counted = 1;
            m_h.push_back(p); void'(m_h.pop_front());
            if (b != p) begin
              err = 1; m_run++;
              if (m_run == 4) begin m_state = M_SEARCH; m_match = 0; end
            end else m_run = 0;
          end
        endcase
      end
      if (c) begin m_errs = 0; m_bits = 0; end
      else begin
        if (err) m_errs++;
        if (counted) m_bits++;
      end
    end
    e.lk  = (m_state == M_LOCKED);
    e.be  = err;
    e.ec  = (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
    e.ecs = (m_errs > 15) ? 4'hF : 4'(m_errs);
    e.bc  = 32'(m_bits);
  endtask

  // ---------------- pattern generator (seed all-zeros) ----------------
  bit g[$] = '{0,0,0,0,0,0,0,0,0,0};
  function automatic bit gen_next();
    bit nb = !(g[0] ^ g[3]);
    g.push_back(nb); void'(g.pop_front());
    return nb;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit v, input bit b, input bit c, input bit r);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_bit = b; clear_cnt = c; reset = r;
    model_update(v, b, c, r, e);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bit_err) pulse_cnt++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || bit_err !== e.be || err_count !== e.ec ||
          err_count_s !== e.ecs || locked_s !== e.lk || bit_err_s !== e.be
`ifdef LFSR_SEQ_CHECKER_BITCNT_EN
          || bit_count !== e.bc || bit_count_s !== e.bc
`endif
          ) begin
        errors++;
        $display("FAIL scoreboard t=%0t: locked=%b bit_err=%b err_count=%0d err_count_s=%0d expected locked=%b bit_err=%b err_count=%0d err_count_s=%0d",
                 $time, locked, bit_err, err_count, err_count_s, e.lk, e.be, e.ec, e.ecs);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit v;
    int base;
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_cnt = 1'b0;

    // Reset
    repeat (3) step(0, 0, 0, 1);
    chk("reset_locked", locked, 0);
    chk("reset_err_count", err_count, 0);
    $display("reset done: locked=%b err_count=%0d", locked, err_count);

    // Clean lock from seed 0: lock on the 30th valid bit
    for (int i = 1; i <= 1000; i++) begin
      step(1, gen_next(), 0, 0);
      if (i == 29) chk("lock_not_before_30", locked, 0);
      if (i == 30) chk("lock_at_30", locked, 1);
    end
    chk("clean_err_count", err_count, 0);
    $display("clean lock: locked=%b err_count=%0d", locked, err_count);

    // Single error
    step(1, !gen_next(), 0, 0);
    chk("single_bit_err", bit_err, 1);
    chk("single_err_count", err_count, 1);
    chk("single_locked", locked, 1);
    step(1, gen_next(), 0, 0);
    chk("single_pulse_width", bit_err, 0);
    $display("single error: err_count=%0d locked=%b", err_count, locked);

    // Loss of lock: 4 consecutive errors, then relock after 20 clean bits
    step(1, gen_next(), 1, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, !gen_next(), 0, 0);
      if (i == 3) chk("still_locked_after_3", locked, 1);
    end
    chk("loss_bit_err", bit_err, 1);
    chk("loss_err_count", err_count, 4);
    chk("loss_unlocked", locked, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, gen_next(), 0, 0);
      if (i == 19) chk("relock_not_before_20", locked, 0);
    end
    chk("relock_at_20", locked, 1);
    $display("loss/relock: err_count=%0d locked=%b", err_count, locked);

    // Random valid gaps while locked
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 2) != 0);
      step(v, v ? gen_next() : 1'($urandom), 0, 0);
    end
    chk("gaps_err_count", err_count, 4);
    chk("gaps_locked", locked, 1);
    $display("gaps: err_count=%0d locked=%b", err_count, locked);

    // Clear on the same cycle as an error
    step(1, !gen_next(), 1, 0);
    chk("clear_vs_err_count", err_count, 0);
    chk("clear_vs_err_pulse", bit_err, 1);
    $display("clear with error: err_count=%0d bit_err=%b", err_count, bit_err);

    // Randomized errors and gaps
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 4) != 0);
      if (v) step(1, gen_next() ^ ($urandom_range(0, 39) == 0), 0, 0);
      else step(0, 1'($urandom), 0, 0);
    end
    repeat (40) step(1, gen_next(), 0, 0);
    chk("random_relocked", locked, 1);
    $display("random phase: err_count=%0d locked=%b", err_count, locked);

    // Saturation of the 4-bit counter with 20 spaced errors
    step(1, gen_next(), 1, 0);
    base = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      step(1, !gen_next(), 0, 0);
      repeat (5) step(1, gen_next(), 0, 0);
    end
    chk("sat_err_count_s", err_count_s, 15);
    chk("sat_err_count", err_count, 20);
    chk("sat_pulses", pulse_cnt - base, 20);
    $display("saturation: err_count_s=%0d pulses=%0d", err_count_s, pulse_cnt - base);

    // Reset while locked
    step(1, gen_next(), 0, 1);
    chk("midreset_locked", locked, 0);
    chk("midreset_err_count", err_count, 0);

    // Lock-up rejection: constant ones
    for (int i = 0; i < 210; i++) step(1, 1, 0, 0);
    chk("lockup_locked", locked, 0);
    chk("lockup_err_count", err_count, 0);
    $display("lockup: locked=%b err_count=%0d", locked, err_count);

    step(0, 0, 0, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
